// File: rtl/sigma_delta_sample_buffer.sv
// First-word fall-through sample FIFO between the sigma-delta ADC and a stalling ready/valid consumer.
// Optional SIGMA_DELTA_BUF_OVF_CNT_EN adds a saturating dropped-sample counter on ovf_count.
module sigma_delta_sample_buffer #(
    parameter  int WDTH  = 16,
    parameter  int DEPTH = 16,
    localparam int LVLW  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WDTH-1:0] in_data,
    input  logic            in_valid,
    input  logic            flush,
    output logic [WDTH-1:0] m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [LVLW-1:0] level,
    output logic            ovf,
`ifdef SIGMA_DELTA_BUF_OVF_CNT_EN
    output logic [15:0]     ovf_count,
`endif
    input  logic            ovf_clr
);

    localparam int AW = $clog2(DEPTH);

    logic [WDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [LVLW-1:0] r_level;
    logic [WDTH-1:0] r_mData;
    logic            r_ovf;

    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [LVLW-1:0] w_remain;
    logic [LVLW-1:0] w_levelNext;
    logic [AW-1:0]   w_headIdx;
    logic [WDTH-1:0] w_headData;

    // The head after this edge is the incoming sample only when no older entry survives the pop.
    always_comb begin
        w_full      = (r_level == LVLW'(DEPTH));
        w_pop       = (r_level != '0) && m_ready && !flush;
        w_push      = in_valid && !flush && (!w_full || w_pop);
        w_drop      = in_valid && !flush && w_full && !w_pop;
        w_remain    = r_level - LVLW'(w_pop);
        w_levelNext = flush ? '0 : (w_remain + LVLW'(w_push));
        w_headIdx   = w_pop ? (r_rdPtr + AW'(1)) : r_rdPtr;
        w_headData  = (w_remain == '0) ? in_data : r_mem[w_headIdx];
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
            r_mData <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (flush) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
            end else begin
                if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
                if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_level <= w_levelNext;
            // m_data keeps its last value once the FIFO runs empty.
            if (w_levelNext != '0) begin
                r_mData <= w_headData;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef SIGMA_DELTA_BUF_OVF_CNT_EN
    logic [15:0] r_ovfCount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovfCount <= '0;
        end else if (ovf_clr) begin
            r_ovfCount <= w_drop ? 16'd1 : 16'd0;
        end else if (w_drop && (r_ovfCount != 16'hFFFF)) begin
            r_ovfCount <= r_ovfCount + 16'd1;
        end
    end

    assign ovf_count = r_ovfCount;
`endif

    assign m_data  = r_mData;
    assign m_valid = (r_level != '0);
    assign level   = r_level;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_sigma_delta_sample_buffer.sv
// Scoreboard bench for sigma_delta_sample_buffer: accepted samples are queued, a monitor checks every pop.
module tb_sigma_delta_sample_buffer;

    localparam int WDTH  = 16;
    localparam int DEPTH = 16;
    localparam int LVLW  = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [WDTH-1:0] in_data;
    logic            in_valid;
    logic            flush;
    logic [WDTH-1:0] m_data;
    logic            m_valid;
    logic            m_ready;
    logic [LVLW-1:0] level;
    logic            ovf;
    logic            ovf_clr;
`ifdef SIGMA_DELTA_BUF_OVF_CNT_EN
    logic [15:0]     ovf_count;
`endif

    int              checkCount = 0;
    int              errorCount = 0;
    int              rxCount    = 0;
    int              modelLevel = 0;
    logic [WDTH-1:0] expQ[$];

    sigma_delta_sample_buffer #(.WDTH(WDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .flush    (flush),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .level    (level),
        .ovf      (ovf),
`ifdef SIGMA_DELTA_BUF_OVF_CNT_EN
        .ovf_count(ovf_count),
`endif
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every accepted pop must present the oldest queued sample.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready && !flush) begin
            checkCount++;
            if (expQ.size() == 0) begin
                errorCount++;
                $display("[TB] FAIL pop_unexpected: got %0h expected none", m_data);
            end else begin
                logic [WDTH-1:0] exp;
                exp = expQ.pop_front();
                rxCount++;
                if (m_data !== exp) begin
                    errorCount++;
                    $display("[TB] FAIL pop_data: got %0h expected %0h at %0t", m_data, exp, $time);
                end
            end
        end
    end

    // Drive one cycle of inputs, update the reference model, and advance past the next edge.
    task automatic applyStimulus(input logic [WDTH-1:0] d, input logic v, input logic r,
                                 input logic f = 1'b0, input logic c = 1'b0);
        bit popNow;
        in_data  = d;
        in_valid = v;
        m_ready  = r;
        flush    = f;
        ovf_clr  = c;
        if (f) begin
            expQ.delete();
            modelLevel = 0;
        end else begin
            popNow = r && (modelLevel > 0);
            if (v && (modelLevel < DEPTH || popNow)) begin
                expQ.push_back(d);
                modelLevel++;
            end
            if (popNow) modelLevel--;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        m_ready  = 1'b0;
        flush    = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    task automatic drainAll(input string name);
        int cycles;
        cycles = 0;
        while (level != 0 && cycles < 4 * DEPTH) begin
            applyStimulus('0, 1'b0, 1'b1);
            cycles++;
        end
        checkOutput({name, "_level"}, 32'(level), 32'd0);
        checkOutput({name, "_queue"}, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
        #12;
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_data", 32'(m_data), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Fall-through latency and single handshake.
        applyStimulus(16'h1234, 1'b1, 1'b0);
        checkOutput("ft_valid", 32'(m_valid), 32'd1);
        checkOutput("ft_data", 32'(m_data), 32'h1234);
        checkOutput("ft_level", 32'(level), 32'd1);
        applyStimulus('0, 1'b0, 1'b1);
        checkOutput("ft_pop_valid", 32'(m_valid), 32'd0);
        checkOutput("ft_pop_level", 32'(level), 32'd0);
        checkOutput("ft_hold_data", 32'(m_data), 32'h1234);

        // Seventeen writes into a stalled FIFO: the last one is dropped.
        for (int i = 0; i < 17; i++) applyStimulus(WDTH'(i - 8), 1'b1, 1'b0);
        checkOutput("full_level", 32'(level), 32'd16);
        checkOutput("full_ovf", 32'(ovf), 32'd1);
        checkOutput("full_head", 32'(m_data), 32'h0000FFF8);
`ifdef SIGMA_DELTA_BUF_OVF_CNT_EN
        checkOutput("full_ovf_count", 32'(ovf_count), 32'd1);
`endif
        drainAll("full_drain");
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_cleared", 32'(ovf), 32'd0);

        // Push and pop together while full: accepted, no overflow.
        for (int i = 0; i < 16; i++) applyStimulus(WDTH'(100 + i), 1'b1, 1'b0);
        applyStimulus(16'd200, 1'b1, 1'b1);
        checkOutput("pp_level", 32'(level), 32'd16);
        checkOutput("pp_ovf", 32'(ovf), 32'd0);
        drainAll("pp_drain");

        // Pointer wrap: sample strobes every other cycle, m_ready toggling each cycle.
        rxCount = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(WDTH'(i), 1'b1, 1'b1);
            applyStimulus('0, 1'b0, 1'b0);
        end
        drainAll("wrap_drain");
        checkOutput("wrap_rx", 32'(rxCount), 32'd100);
        checkOutput("wrap_ovf", 32'(ovf), 32'd0);

        // Build 5 entries with ovf set, then flush against a push and pop.
        for (int i = 0; i < 17; i++) applyStimulus(WDTH'(300 + i), 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) applyStimulus('0, 1'b0, 1'b1);
        checkOutput("pre_flush_level", 32'(level), 32'd5);
        applyStimulus(16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_level", 32'(level), 32'd0);
        checkOutput("flush_valid", 32'(m_valid), 32'd0);
        checkOutput("flush_ovf", 32'(ovf), 32'd1);

        // ovf_clr coinciding with a drop: set wins.
        for (int i = 0; i < 16; i++) applyStimulus(WDTH'(400 + i), 1'b1, 1'b0);
        applyStimulus(16'h7777, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_drop_ovf", 32'(ovf), 32'd1);
        checkOutput("clr_drop_level", 32'(level), 32'd16);
`ifdef SIGMA_DELTA_BUF_OVF_CNT_EN
        checkOutput("clr_drop_count", 32'(ovf_count), 32'd1);
`endif
        drainAll("clr_drain");

        // Asynchronous reset between edges with 7 entries stored.
        for (int i = 0; i < 7; i++) applyStimulus(WDTH'(500 + i), 1'b1, 1'b0);
        checkOutput("pre_rst_level", 32'(level), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_level", 32'(level), 32'd0);
        checkOutput("arst_valid", 32'(m_valid), 32'd0);
        checkOutput("arst_ovf", 32'(ovf), 32'd0);
        expQ.delete();
        modelLevel = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/sigma_delta_sample_buffer.md
Name: sigma_delta_sample_buffer

Overview:
Downstream of sigma_delta_adc. Buffers the decimated signed PCM samples (one-cycle valid strobe, no backpressure) in a small synchronous FIFO. Presents them on a ready/valid stream for consumers that stall, such as a serializer, a DMA or a bench scoreboard. Drops samples on overflow and reports the loss instead of corrupting the stream.

Parameters:
WDTH, 16, sample width in bits; matches the ADC output width.
DEPTH, 16, FIFO entries; power of two, at least 2.
LVLW, $clog2(DEPTH)+1, width of the fill-level output; derived, not overridden.

Ports:
clk  input  1  system clock, same domain as the ADC.
rst  input  1  asynchronous, active-high reset.
in_data  input  WDTH  signed sample from the ADC (adc_s_output).
in_valid  input  1  one-cycle strobe; sample is present (adc_valid).
flush  input  1  synchronous clear of FIFO contents.
m_data  output  WDTH  head-of-FIFO sample.
m_valid  output  1  m_data is valid.
m_ready  input  1  consumer accepts m_data this cycle.
level  output  LVLW  number of stored entries, 0..DEPTH.
ovf  output  1  sticky overflow flag.
ovf_clr  input  1  synchronous clear of ovf.

Behaviour:
- Reset (async, rst=1):
  - wr_ptr, rd_ptr and level go to 0.
  - m_valid=0, m_data=0, ovf=0.
  - Storage RAM is not reset.
- Pointers:
  - log2(DEPTH) bits each; wrap naturally from DEPTH-1 to 0.
  - The count register is authoritative for full/empty: full is level==DEPTH, empty is level==0.
- Read handshake:
  - A pop occurs when m_valid && m_ready.
  - m_valid equals (level!=0). It is never asserted speculatively.
  - m_data and m_valid are stable while m_valid=1 and m_ready=0.
- Write, empty and not full: when in_valid=1, in_data is stored at wr_ptr and wr_ptr is incremented.
- Write when full:
  - If a pop occurs in the same cycle, the write is accepted and level is unchanged.
  - Otherwise the sample is dropped, the FIFO contents are untouched and ovf is set.
- Level update: level += push − pop. A push and a pop in the same cycle leave it unchanged.
- Latency (first-word fall-through):
  - A sample written at edge N into an empty FIFO gives m_valid=1 and m_data=that sample after edge N.
  - The data is therefore visible in the cycle following the strobe.
- Data path:
  - m_data is driven from the RAM at rd_ptr, registered so there is no combinational path from in_data.
  - Reading the RAM is allowed to be combinational from registered rd_ptr.
  - m_data holds its last value when empty.
- Flush:
  - Sets both pointers and level to 0 at the next edge, and m_valid drops.
  - Takes priority over a simultaneous push and pop; both are discarded.
  - Does not affect ovf.
- ovf_clr:
  - Clears ovf at the next edge.
  - If an overflow drop occurs in the same cycle, ovf is set, because set wins.
- Arithmetic: no arithmetic is applied to the data; samples pass bit-exact, sign preserved.
- Reset mid-operation: everything returns immediately to the reset state; the clock is not required.

Optional Feature:
SIGMA_DELTA_BUF_OVF_CNT_EN
- Defined:
  - Adds output ovf_count [15:0], which counts dropped samples.
  - The count saturates at 16'hFFFF.
  - It is cleared by rst and by ovf_clr.
  - On a simultaneous clear and drop, the count is 1.
- Undefined: the port and counter are absent; ovf alone signals loss.

Test Plan:
- Fill latency and handshake: reset, m_ready=0, strobe in_data=16'h1234 once.
  - Next cycle: m_valid=1, m_data=16'h1234, level=1.
  - Assert m_ready for 1 cycle: m_valid=0, level=0.
- Fill to full and overflow: with DEPTH=16 and m_ready=0, write 17 samples −8..8.
  - level=16, ovf=1.
  - Draining gives −8..7 in order; 8 is absent.
  - With SIGMA_DELTA_BUF_OVF_CNT_EN defined: ovf_count=1.
- Full with simultaneous push and pop: FIFO full, in_valid=1 and m_ready=1 in the same cycle.
  - level stays 16, ovf stays 0.
  - The new sample appears last when draining.
- Pointer wrap: stream 100 samples (ramp 0..99) with m_ready toggling 1/0 every cycle.
  - All 100 are received in order, with no loss and ovf=0.
- Flush and ovf_clr priority:
  - FIFO holds 5 entries and ovf=1. Assert flush, in_valid and m_ready together: next cycle level=0, m_valid=0, ovf=1.
  - Then assert ovf_clr together with an overflow drop: ovf remains 1.
- Async reset mid-stream: assert rst between clock edges with level=7.
  - level=0, m_valid=0 and ovf=0 immediately, before the next edge.
